spi_master: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0), MSB-first byte master; the host end of the display-controller SPI link.

---
 rtl/spi_master_pkg.sv | 16 +
 rtl/spi_master.sv | 177 +++++++++++++++++
 tb/tb_spi_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Constants shared by both ends of the display SPI link, plus the master's state encoding.
package spi_master_pkg;

    localparam bit SPI_SS_ACTIVE_DEFAULT = 1'b1;
    localparam int SPI_BITS              = 8;

    // IDLE wait | SETUP ss + msb | SHIFT_HI/LO sclk phases | HOLD ss kept | TEARDOWN ss tail | GUARD gap
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_TEARDOWN = 3'd5;
    localparam logic [2:0] ST_GUARD    = 3'd6;

endpackage

// File: rtl/spi_master.sv
// SPI mode-0 MSB-first byte master for the display link; every phase is CLK_DIV clk cycles,
// timed by one down-counter.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter bit SS_ACTIVE = SPI_SS_ACTIVE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_valid,
    input  logic                tx_last,
    output logic                tx_ready,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy,
    output logic                sclk,
    output logic                ss,
    output logic                mosi,
    input  logic                miso
);

    localparam int            CW       = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(SPI_BITS - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("spi_master: CLK_DIV must be at least 2");
        end
    endgenerate

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [SPI_BITS-2:0] tx_sr_q, tx_sr_d;
    logic [SPI_BITS-2:0] rx_sr_q, rx_sr_d;
    logic                last_q, last_d;
    logic                sclk_q, sclk_d;
    logic                ss_q, ss_d;
    logic                mosi_q, mosi_d;
    logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                miso_meta_q, miso_sync_q;
    logic                cnt_done;
    logic                accept;

    assign tx_ready = !rst && (state_q == ST_IDLE || state_q == ST_HOLD);
    assign busy     = !rst && (state_q != ST_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign cnt_done = (cnt_q == '0);

    assign sclk     = sclk_q;
    assign ss       = ss_q;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        last_d     = last_q;
        sclk_d     = sclk_q;
        ss_d       = ss_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if (!cnt_done) begin
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    state_d   = ST_SETUP;
                    cnt_d     = CNT_LOAD;
                    bit_cnt_d = '0;
                    tx_sr_d   = tx_data[SPI_BITS-2:0];
                    last_d    = tx_last;
                    ss_d      = SS_ACTIVE;
                    mosi_d    = tx_data[SPI_BITS-1];
                end
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    state_d = ST_SHIFT_HI;
                    cnt_d   = CNT_LOAD;
                    sclk_d  = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                // Falling edge: capture synchronized miso and advance mosi together.
                if (cnt_done) begin
                    sclk_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                    rx_sr_d = {rx_sr_q[SPI_BITS-3:0], miso_sync_q};
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = {rx_sr_q, miso_sync_q};
                        rx_valid_d = 1'b1;
                        state_d    = last_q ? ST_TEARDOWN : ST_SHIFT_LO;
                    end else begin
                        state_d = ST_SHIFT_LO;
                        mosi_d  = tx_sr_q[SPI_BITS-2];
                        tx_sr_d = {tx_sr_q[SPI_BITS-3:0], 1'b0};
                    end
                end
            end
            ST_SHIFT_LO: begin
                // After the last bit this low phase pads the gap before HOLD opens.
                if (cnt_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d   = ST_SHIFT_HI;
                        cnt_d     = CNT_LOAD;
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_TEARDOWN: begin
                if (cnt_done) begin
                    state_d = ST_GUARD;
                    cnt_d   = CNT_LOAD;
                    ss_d    = ~SS_ACTIVE;
                    mosi_d  = 1'b0;
                end
            end
            ST_GUARD: begin
                if (cnt_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            last_q      <= 1'b0;
            sclk_q      <= 1'b0;
            ss_q        <= ~SS_ACTIVE;
            mosi_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            last_q      <= last_d;
            sclk_q      <= sclk_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_meta_q <= miso;
            miso_sync_q <= miso_meta_q;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: per-cycle pin expectations derived from the link timing rules,
// loopback / tied / echo-slave miso sources, and a second instance at CLK_DIV=2.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       sel2 = 1'b0;
    logic [1:0] miso_mode = 2'd1;
    logic       miso_const = 1'b0;
    logic       tx_valid1, tx_valid2, miso;

    logic       rdy1, rxv1, busy1, sclk1, ss1, mosi1;
    logic [7:0] rxd1;
    logic       rdy2, rxv2, busy2, sclk2, ss2, mosi2;
    logic [7:0] rxd2;
    logic       o_rdy, o_rxv, o_busy, o_sclk, o_ss, o_mosi;
    logic [7:0] o_rxd;

    int checks = 0;
    int failures = 0;

    // Echo slave model: returns the previous byte it received.
    logic       slv_miso = 1'b0;
    logic [7:0] slv_sh = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic [7:0] slv_next = 8'h00;
    int         slv_cnt = 0;
    bit         slv_reload = 1'b0;
    logic       slv_pss = 1'b0;
    logic       slv_psclk = 1'b0;
    logic [7:0] slv_q[$];

    assign tx_valid1 = tx_valid && !sel2;
    assign tx_valid2 = tx_valid && sel2;
    assign miso = (miso_mode == 2'd2) ? slv_miso :
                  (miso_mode == 2'd1) ? (sel2 ? mosi2 : mosi1) : miso_const;

    assign o_rdy  = sel2 ? rdy2  : rdy1;
    assign o_rxv  = sel2 ? rxv2  : rxv1;
    assign o_busy = sel2 ? busy2 : busy1;
    assign o_sclk = sel2 ? sclk2 : sclk1;
    assign o_ss   = sel2 ? ss2   : ss1;
    assign o_mosi = sel2 ? mosi2 : mosi1;
    assign o_rxd  = sel2 ? rxd2  : rxd1;

    spi_master #(.CLK_DIV(4), .SS_ACTIVE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid1), .tx_last(tx_last),
        .tx_ready(rdy1), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1),
        .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(miso)
    );

    spi_master #(.CLK_DIV(2), .SS_ACTIVE(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid2), .tx_last(tx_last),
        .tx_ready(rdy2), .rx_data(rxd2), .rx_valid(rxv2), .busy(busy2),
        .sclk(sclk2), .ss(ss2), .mosi(mosi2), .miso(miso)
    );

    always @(ss1 or sclk1) begin
        if (miso_mode == 2'd2) begin
            if (ss1 === 1'b1 && slv_pss !== 1'b1) begin
                slv_sh     = slv_next;
                slv_miso   = slv_next[7];
                slv_cnt    = 0;
                slv_reload = 1'b0;
            end else if (ss1 === 1'b1 && sclk1 === 1'b1 && slv_psclk !== 1'b1) begin
                slv_rx = {slv_rx[6:0], mosi1};
                slv_cnt++;
                if (slv_cnt == 8) begin
                    slv_q.push_back(slv_rx);
                    slv_next   = slv_rx;
                    slv_cnt    = 0;
                    slv_reload = 1'b1;
                end
            end else if (ss1 === 1'b1 && sclk1 === 1'b0 && slv_psclk === 1'b1) begin
                if (slv_reload) begin
                    slv_sh     = slv_next;
                    slv_reload = 1'b0;
                end else begin
                    slv_sh = slv_sh << 1;
                end
                slv_miso = slv_sh[7];
            end
        end
        slv_pss   = ss1;
        slv_psclk = sclk1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte (selected DUT must be ready) and checks every cycle until the master
    // is ready again (IDLE for last=1, first HOLD cycle for last=0).
    task automatic run_xfer(input logic [7:0] b, input bit l, input logic [7:0] exp_rx,
                            input int abort_at, input bit pre_next, input logic [7:0] nb);
        int         d, n_end, k;
        logic       e_ss, e_sclk, e_mosi, e_rxv, e_rdy, e_busy;
        logic [5:0] got, want;
        logic       p_sclk, p_mosi;
        d = sel2 ? 2 : 4;
        tx_data  = b;
        tx_last  = l;
        tx_valid = 1'b1;
        #1;
        checks++;
        if (o_rdy !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready byte=%02h got=%b want=1", b, o_rdy);
        end
        step();
        tx_valid = 1'b0;
        n_end = l ? 1 + 18 * d : 1 + 17 * d;
        p_sclk = 1'b0;
        p_mosi = 1'b0;
        for (int c = 1; c <= n_end; c++) begin
            e_ss   = l ? (c < 1 + 17 * d) : 1'b1;
            e_sclk = (c >= 1 + d) && (c < 1 + 16 * d) && ((((c - 1 - d) / d) % 2) == 0);
            k = (c - 1) / (2 * d);
            if (k > 7) k = 7;
            e_mosi = (l && c >= 1 + 17 * d) ? 1'b0 : b[7 - k];
            e_rxv  = (c == 1 + 16 * d);
            e_rdy  = l ? (c >= 1 + 18 * d) : (c >= 1 + 17 * d);
            e_busy = l ? (c < 1 + 18 * d) : 1'b1;
            want = {e_ss, e_sclk, e_mosi, e_rxv, e_rdy, e_busy};
            got  = {o_ss, o_sclk, o_mosi, o_rxv, o_rdy, o_busy};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL xfer_wave div=%0d byte=%02h cycle=%0d got=%b want=%b (ss,sclk,mosi,rx_valid,tx_ready,busy)",
                         d, b, c, got, want);
            end
            if (c > 1 && p_sclk === 1'b1 && o_sclk === 1'b1) begin
                checks++;
                if (o_mosi !== p_mosi) begin
                    failures++;
                    $display("FAIL mosi_stable_high div=%0d byte=%02h cycle=%0d got=%b want=%b", d, b, c, o_mosi, p_mosi);
                end
            end
            p_sclk = o_sclk;
            p_mosi = o_mosi;
            if (c == 1 + 16 * d) begin
                checks++;
                if (o_rxd !== exp_rx) begin
                    failures++;
                    $display("FAIL rx_data div=%0d byte=%02h got=%02h want=%02h", d, b, o_rxd, exp_rx);
                end
                if (pre_next) begin
                    tx_data  = nb;
                    tx_last  = 1'b1;
                    tx_valid = 1'b1;
                end
            end
            if (abort_at != 0 && c == abort_at) begin
                rst = 1'b1;
                return;
            end
            if (c < n_end) step();
        end
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        tx_last = 1'b1;
        repeat (3) step();
        got = {sclk1, ss1, mosi1, rxv1, rdy1, busy1, rxd1};
        checks++;
        if (got !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b (sclk,ss,mosi,rx_valid,tx_ready,busy,rx_data)", got, 14'd0);
        end
        rst = 1'b0;
        tx_valid = 1'b0;
        #1;
        checks++;
        if ({rdy1, busy1} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release_ready got=%b want=10 (tx_ready,busy)", {rdy1, busy1});
        end
        repeat (2) step();
        checks++;
        if ({ss1, sclk1, rdy1, busy1} !== 4'b0010) begin
            failures++;
            $display("FAIL reset_valid_ignored got=%b want=0010 (ss,sclk,tx_ready,busy)", {ss1, sclk1, rdy1, busy1});
        end
    endtask

    task automatic test_loopback();
        logic [7:0] b;
        miso_mode = 2'd1;
        run_xfer(8'hA5, 1'b1, 8'hA5, 0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            run_xfer(b, 1'b1, b, 0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_slave_echo();
        miso_mode = 2'd2;
        run_xfer(8'h3C, 1'b0, 8'h00, 0, 1'b1, 8'h81);
        run_xfer(8'h81, 1'b1, 8'h3C, 0, 1'b0, 8'h00);
        checks++;
        if (slv_q.size() != 2) begin
            failures++;
            $display("FAIL slave_count got=%0d want=2", slv_q.size());
        end else begin
            checks++;
            if (slv_q[0] !== 8'h3C || slv_q[1] !== 8'h81) begin
                failures++;
                $display("FAIL slave_data got=%02h,%02h want=3c,81", slv_q[0], slv_q[1]);
            end
        end
        miso_mode = 2'd1;
    endtask

    task automatic test_hold();
        logic [5:0] got;
        int bad;
        miso_mode = 2'd0;
        miso_const = 1'b0;
        run_xfer(8'hFF, 1'b0, 8'h00, 0, 1'b0, 8'h00);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            got = {ss1, sclk1, mosi1, rxv1, rdy1, busy1};
            checks++;
            if (got !== 6'b101011) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL hold_idle cycle=%0d got=%b want=101011 (ss,sclk,mosi,rx_valid,tx_ready,busy)", i, got);
            end
        end
        run_xfer(8'h00, 1'b1, 8'h00, 0, 1'b0, 8'h00);
        miso_mode = 2'd1;
    endtask

    task automatic test_reset_mid();
        logic [11:0] got;
        miso_mode = 2'd1;
        run_xfer(8'hC3, 1'b1, 8'hC3, 0, 1'b0, 8'h00);
        run_xfer(8'h55, 1'b1, 8'h55, 30, 1'b0, 8'h00);
        step();
        got = {sclk1, ss1, mosi1, rxv1, rxd1};
        checks++;
        if (got !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid got=%b want=%b (sclk,ss,mosi,rx_valid,rx_data)", got, 12'd0);
        end
        rst = 1'b0;
        run_xfer(8'h55, 1'b1, 8'h55, 0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        bit         l;
        int         gap;
        miso_mode = 2'd1;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            l = (i == 9) ? 1'b1 : 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            run_xfer(b, l, b, 0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_clkdiv2();
        logic [7:0] b;
        sel2 = 1'b1;
        miso_mode = 2'd0;
        miso_const = 1'b1;
        run_xfer(8'h00, 1'b1, 8'hFF, 0, 1'b0, 8'h00);
        miso_const = 1'b0;
        run_xfer(8'hFF, 1'b1, 8'h00, 0, 1'b0, 8'h00);
        miso_mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            run_xfer(b, (i == 2) ? 1'b1 : 1'b0, b, 0, 1'b0, 8'h00);
        end
        sel2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave_echo();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_clkdiv2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
